// File: rtl/keccak_squeeze_ser_pkg.sv
// Shared Keccak squeeze definitions: lane geometry, rate presets and the
// serializer state encoding.
package keccak_squeeze_ser_pkg;

    localparam int BW_LANE        = 64;
    localparam int RATE_SHAKE128  = 21;
    localparam int RATE_SHAKE256  = 17;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_EMIT = 2'd3;

endpackage

// File: rtl/keccak_squeeze_ser_if.sv
// Squeeze serializer bus: permutation handshake towards the round engine and
// the byte-keep word stream towards the XOF consumer.
interface keccak_squeeze_ser_if
    import keccak_squeeze_ser_pkg::*;
#(
    parameter int RATE_LANES = RATE_SHAKE128,
    parameter int BW_LEN     = 16,
    parameter int BW_DATA    = BW_LANE
);
    logic                       i_start;
    logic [BW_LEN-1:0]          i_len;
    logic                       o_perm_req;
    logic                       i_state_vld;
    logic [RATE_LANES*64-1:0]   i_state;
    logic [BW_DATA-1:0]         o_data;
    logic                       o_data_vld;
    logic                       i_data_rdy;
    logic [7:0]                 o_data_keep;
    logic                       o_data_last;
    logic                       o_busy;

    modport master (
        input  i_start, i_len, i_state_vld, i_state, i_data_rdy,
        output o_perm_req, o_data, o_data_vld, o_data_keep, o_data_last, o_busy
    );

    modport slave (
        output i_start, i_len, i_state_vld, i_state, i_data_rdy,
        input  o_perm_req, o_data, o_data_vld, o_data_keep, o_data_last, o_busy
    );
endinterface

// File: rtl/keccak_squeeze_ser_lane_swap.sv
// Byte reversal of one lane so lane byte 0 lands in the top byte, with the
// bytes beyond the requested count zeroed and flagged in an MSB-first keep.
module keccak_squeeze_ser_lane_swap
    import keccak_squeeze_ser_pkg::*;
(
    input  logic [BW_LANE-1:0] lane,
    input  logic [3:0]         nbytes,
    output logic [BW_LANE-1:0] data,
    output logic [7:0]         keep
);
    always_comb begin
        data = '0;
        keep = '0;
        for (int unsigned j = 0; j < 8; j++) begin
            if (4'(j) < nbytes) begin
                data[BW_LANE-1-8*j -: 8] = lane[8*j +: 8];
                keep[7-j]                = 1'b1;
            end
        end
    end
endmodule

// File: rtl/keccak_squeeze_ser.sv
// Squeeze-side serializer: captures a permuted rate block and streams it out
// lane by lane, requesting further permutations until the byte count is met.
module keccak_squeeze_ser
    import keccak_squeeze_ser_pkg::*;
#(
    parameter int BW_DATA    = 64,
    parameter int RATE_LANES = RATE_SHAKE128,
    parameter int BW_LEN     = 16
)(
    input  logic                 i_clk,
    input  logic                 i_rst,
    keccak_squeeze_ser_if.master bus
);
    localparam int LW = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;
    localparam logic [LW-1:0] LAST_IDX = LW'(RATE_LANES - 1);

    logic [1:0]          state;
    logic [BW_LEN-1:0]   remaining;
    logic [LW-1:0]       lane_idx;
    logic [BW_LANE-1:0]  lane_buf [RATE_LANES];

    logic [BW_LEN-1:0]   rem_step;
    logic [BW_LEN-1:0]   rem_next;
    logic [LW-1:0]       next_idx;
    logic [BW_LANE-1:0]  sel_lane;
    logic [BW_LEN-1:0]   sel_rem;
    logic [3:0]          sel_cnt;
    logic                sel_last;
    logic [BW_DATA-1:0]  swap_data;
    logic [7:0]          swap_keep;

    // Outputs are registered, so the swap works on the beat that will be
    // presented next: lane 0 of the incoming block in WAIT, the following
    // buffered lane in EMIT.
    always_comb begin
        rem_step = (remaining >= BW_LEN'(8)) ? BW_LEN'(8) : remaining;
        rem_next = remaining - rem_step;
        next_idx = (lane_idx == LAST_IDX) ? '0 : lane_idx + 1'b1;
        sel_lane = (state == ST_WAIT) ? bus.i_state[BW_LANE-1:0] : lane_buf[next_idx];
        sel_rem  = (state == ST_WAIT) ? remaining : rem_next;
        sel_cnt  = (sel_rem >= BW_LEN'(8)) ? 4'd8 : sel_rem[3:0];
        sel_last = (sel_rem <= BW_LEN'(8));
    end

    keccak_squeeze_ser_lane_swap u_lane_swap (
        .lane   (sel_lane),
        .nbytes (sel_cnt),
        .data   (swap_data),
        .keep   (swap_keep)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state           <= ST_IDLE;
            remaining       <= '0;
            lane_idx        <= '0;
            for (int unsigned k = 0; k < RATE_LANES; k++) begin
                lane_buf[k] <= '0;
            end
            bus.o_perm_req  <= 1'b0;
            bus.o_data      <= '0;
            bus.o_data_vld  <= 1'b0;
            bus.o_data_keep <= '0;
            bus.o_data_last <= 1'b0;
            bus.o_busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.i_start && (bus.i_len != '0)) begin
                        remaining      <= bus.i_len;
                        bus.o_perm_req <= 1'b1;
                        bus.o_busy     <= 1'b1;
                        state          <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    bus.o_perm_req <= 1'b0;
                    state          <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.i_state_vld) begin
                        for (int unsigned k = 0; k < RATE_LANES; k++) begin
                            lane_buf[k] <= bus.i_state[64*k +: 64];
                        end
                        lane_idx        <= '0;
                        bus.o_data      <= swap_data;
                        bus.o_data_keep <= swap_keep;
                        bus.o_data_last <= sel_last;
                        bus.o_data_vld  <= 1'b1;
                        state           <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (bus.o_data_vld && bus.i_data_rdy) begin
                        remaining <= rem_next;
                        if (rem_next == '0) begin
                            lane_idx        <= '0;
                            bus.o_data      <= '0;
                            bus.o_data_keep <= '0;
                            bus.o_data_last <= 1'b0;
                            bus.o_data_vld  <= 1'b0;
                            bus.o_busy      <= 1'b0;
                            state           <= ST_IDLE;
                        end else if (lane_idx == LAST_IDX) begin
                            lane_idx        <= '0;
                            bus.o_data      <= '0;
                            bus.o_data_keep <= '0;
                            bus.o_data_last <= 1'b0;
                            bus.o_data_vld  <= 1'b0;
                            bus.o_perm_req  <= 1'b1;
                            state           <= ST_REQ;
                        end else begin
                            lane_idx        <= next_idx;
                            bus.o_data      <= swap_data;
                            bus.o_data_keep <= swap_keep;
                            bus.o_data_last <= sel_last;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_keccak_squeeze_ser.sv
// Scoreboard bench for the squeeze serializer: a permutation responder pushes
// expected beats when it delivers a block, the output monitor pops and compares.
module tb_keccak_squeeze_ser;
    localparam int RL = 21;
    localparam int RATE_BYTES = RL * 8;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    keccak_squeeze_ser_if #(.RATE_LANES(RL), .BW_LEN(16), .BW_DATA(64)) bus ();

    keccak_squeeze_ser #(.BW_DATA(64), .RATE_LANES(RL), .BW_LEN(16)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    beat_t            exp_q[$];
    logic [RL*64-1:0] block_q[$];
    int               total = 0;
    int               bad = 0;
    int               exp_rem = 0;
    int               perm_cnt = 0;
    int               beats_seen = 0;
    int               rdy_mode = 0;
    logic [63:0]      last_data = '0;
    logic [7:0]       last_keep = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference: lane byte i goes to output byte position 7-i.
    function automatic beat_t model_beat(input logic [63:0] lane, input int rem);
        beat_t b;
        int    n;
        n = (rem >= 8) ? 8 : rem;
        b.data = '0;
        b.keep = '0;
        for (int i = 0; i < n; i++) begin
            b.data = b.data | (64'(lane[8*i +: 8]) << (56 - 8*i));
            b.keep[7-i] = 1'b1;
        end
        b.last = (rem <= 8);
        return b;
    endfunction

    // Permutation responder
    initial begin
        logic [RL*64-1:0] blk;
        int               d;
        bus.i_state_vld = 1'b0;
        bus.i_state     = '0;
        forever begin
            @(negedge clk);
            if (bus.o_perm_req === 1'b1 && rst === 1'b0) begin
                d = $urandom_range(0, 3);
                @(posedge clk);
                repeat (d) @(posedge clk);
                #1;
                if (block_q.size() > 0) begin
                    blk = block_q.pop_front();
                end else begin
                    for (int k = 0; k < RL; k++) blk[64*k +: 64] = {$urandom, $urandom};
                end
                for (int k = 0; k < RL && exp_rem > 0; k++) begin
                    exp_q.push_back(model_beat(blk[64*k +: 64], exp_rem));
                    exp_rem -= (exp_rem >= 8) ? 8 : exp_rem;
                end
                bus.i_state     = blk;
                bus.i_state_vld = 1'b1;
                @(posedge clk);
                #1;
                bus.i_state_vld = 1'b0;
            end
        end
    end

    // Consumer readiness
    initial begin
        bus.i_data_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.i_data_rdy = 1'b1;
                1:       bus.i_data_rdy = ($urandom_range(0, 99) >= 30);
                default: bus.i_data_rdy = 1'b0;
            endcase
        end
    end

    // Output monitor
    initial begin
        logic  stalled;
        beat_t held;
        beat_t e;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                stalled = 1'b0;
            end else begin
                if (bus.o_perm_req === 1'b1) perm_cnt++;
                if (stalled) begin
                    chk("hold_vld",  64'(bus.o_data_vld),  64'(1));
                    chk("hold_data", bus.o_data,           held.data);
                    chk("hold_keep", 64'(bus.o_data_keep), 64'(held.keep));
                    chk("hold_last", 64'(bus.o_data_last), 64'(held.last));
                end
                if (bus.o_data_vld && bus.i_data_rdy) begin
                    beats_seen++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 64'(1), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("data", bus.o_data,           e.data);
                        chk("keep", 64'(bus.o_data_keep), 64'(e.keep));
                        chk("last", 64'(bus.o_data_last), 64'(e.last));
                    end
                    last_data = bus.o_data;
                    last_keep = bus.o_data_keep;
                end
                stalled = bus.o_data_vld && !bus.i_data_rdy;
                held    = {bus.o_data, bus.o_data_keep, bus.o_data_last};
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic pulse_start(input int len);
        @(posedge clk);
        #1;
        bus.i_start = 1'b1;
        bus.i_len   = 16'(len);
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int p0, input int nperm);
        int c;
        c = 0;
        while ((bus.o_busy || exp_q.size() > 0) && c < 5000) begin
            @(posedge clk);
            c++;
        end
        #1;
        if (c >= 5000) chk({tag, "_timeout"}, 64'(1), 64'(0));
        chk({tag, "_perm"},  64'(perm_cnt - p0), 64'(nperm));
        chk({tag, "_qleft"}, 64'(exp_q.size()),  64'(0));
    endtask

    task automatic squeeze(input string tag, input int len);
        int p0;
        p0      = perm_cnt;
        exp_rem = len;
        pulse_start(len);
        wait_idle(tag, p0, (len + RATE_BYTES - 1) / RATE_BYTES);
    endtask

    task automatic chk_quiet(input string pfx);
        chk({pfx, "_perm"}, 64'(bus.o_perm_req),  64'(0));
        chk({pfx, "_vld"},  64'(bus.o_data_vld),  64'(0));
        chk({pfx, "_last"}, 64'(bus.o_data_last), 64'(0));
        chk({pfx, "_busy"}, 64'(bus.o_busy),      64'(0));
        chk({pfx, "_data"}, bus.o_data,           64'(0));
        chk({pfx, "_keep"}, 64'(bus.o_data_keep), 64'(0));
    endtask

    task automatic push_block(input logic [63:0] lane0);
        logic [RL*64-1:0] blk;
        for (int k = 0; k < RL; k++) blk[64*k +: 64] = {$urandom, $urandom};
        blk[63:0] = lane0;
        block_q.push_back(blk);
    endtask

    initial begin
        int p0;
        int c;
        int b0;
        rst         = 1'b1;
        bus.i_start = 1'b0;
        bus.i_len   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_quiet("reset");
        rst = 1'b0;

        // single full lane
        push_block(64'h0807060504030201);
        squeeze("t1", 8);
        chk("t1_data", last_data,      64'h0102030405060708);
        chk("t1_keep", 64'(last_keep), 64'h00000000000000FF);

        // partial lane, unkept bytes zero
        push_block(64'hDEADBE0000CCBBAA);
        squeeze("t2", 3);
        chk("t2_data", last_data,      64'hAABBCC0000000000);
        chk("t2_keep", 64'(last_keep), 64'h00000000000000E0);

        // exactly one block, then one lane into a second block
        squeeze("t3a", 168);
        squeeze("t3b", 176);
        chk("t3b_keep", 64'(last_keep), 64'h00000000000000FF);

        // consumer backpressure
        rdy_mode = 1;
        squeeze("t4a", 200);
        squeeze("t4b", 37);
        squeeze("t4c", 350);
        squeeze("t4d", 1);
        rdy_mode = 0;

        // zero-length start is ignored
        p0 = perm_cnt;
        pulse_start(0);
        repeat (5) @(posedge clk);
        #1;
        chk("t5_busy", 64'(bus.o_busy),     64'(0));
        chk("t5_perm", 64'(perm_cnt - p0), 64'(0));

        // start while emitting is ignored
        p0       = perm_cnt;
        exp_rem  = 40;
        rdy_mode = 2;
        pulse_start(40);
        c = 0;
        while (!bus.o_data_vld && c < 100) begin
            @(posedge clk);
            c++;
        end
        if (c >= 100) chk("t5_vld_timeout", 64'(1), 64'(0));
        pulse_start(8);
        rdy_mode = 0;
        wait_idle("t5b", p0, 1);

        // reset in the middle of a block
        exp_rem = 168;
        b0      = beats_seen;
        pulse_start(168);
        c = 0;
        while ((beats_seen - b0) < 5 && c < 200) begin
            @(posedge clk);
            c++;
        end
        if (c >= 200) chk("t6_beat_timeout", 64'(1), 64'(0));
        #1;
        rst = 1'b1;
        #1;
        chk_quiet("t6_rst");
        exp_q.delete();
        block_q.delete();
        exp_rem = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        push_block(64'h1122334455667788);
        squeeze("t6b", 8);
        chk("t6b_data", last_data,      64'h8877665544332211);
        chk("t6b_keep", 64'(last_keep), 64'h00000000000000FF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
